// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator for the PET bus-bridge command protocol: 4 bytes per request, one cs_n frame per byte.
// Optional read path enabled by defining SPI_CMD_MASTER_READ_EN.
module spi_cmd_master #(
    parameter int SCLK_DIV  = 2,
    parameter int CS_GAP    = 4,
    parameter int READ_WAIT = 16
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw_b,
    input  logic [16:0] addr,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

`ifdef SPI_CMD_MASTER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    localparam int MAX_A = (SCLK_DIV > CS_GAP) ? SCLK_DIV : CS_GAP;
    localparam int MAX_T = (MAX_A > READ_WAIT) ? MAX_A : READ_WAIT;
    localparam int CW    = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(READ_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SCLK_HI, SCLK_LO, GAP, WAIT, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [7:0]    sh;
    logic [7:0]    rx;
    logic          is_read;
    logic [16:0]   addr_q;
    logic [7:0]    wr_q;
    logic          rd_req;
    logic [7:0]    next_byte;

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic rd,
                                              input logic [16:0] a, input logic [7:0] d);
        case (idx)
            2'd0:    return {rd, a[16], 6'd0};
            2'd1:    return a[15:8];
            2'd2:    return a[7:0];
            default: return rd ? 8'h00 : d;
        endcase
    endfunction

    assign rd_req = READ_EN && rw_b;

    // Leaving WAIT, byte_cnt already points at B3; leaving GAP it still points at the byte just sent.
    always_comb begin
        next_byte = frame_byte((state == WAIT) ? byte_cnt : byte_cnt + 2'd1, is_read, addr_q, wr_q);
    end

    // NOTE: every register here uses <= so all same-edge reads see pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sh       <= '0;
            rx       <= '0;
            is_read  <= 1'b0;
            addr_q   <= '0;
            wr_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= 8'h00;
            spi_sclk <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_read  <= rd_req;
                        addr_q   <= addr;
                        wr_q     <= wr_data;
                        sh       <= {rd_req, addr[16], 6'd0};
                        spi_mosi <= rd_req;
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        cnt      <= '0;
                        state    <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        spi_sclk <= 1'b1;
                        rx       <= {rx[6:0], spi_miso};
                        bit_cnt  <= '0;
                        state    <= SCLK_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCLK_HI: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        spi_sclk <= 1'b0;
                        sh       <= {sh[6:0], 1'b0};
                        spi_mosi <= sh[6];
                        bit_cnt  <= bit_cnt + 4'd1;
                        state    <= SCLK_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCLK_LO: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == 4'd8) begin
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                            state    <= GAP;
                        end else begin
                            spi_sclk <= 1'b1;
                            rx       <= {rx[6:0], spi_miso};
                            state    <= SCLK_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= DONE;
                        end else if (is_read && byte_cnt == 2'd2 && READ_WAIT > 0) begin
                            state <= WAIT;
                        end else begin
                            sh       <= next_byte;
                            spi_mosi <= next_byte[7];
                            spi_cs_n <= 1'b0;
                            state    <= CS_SETUP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt      <= '0;
                        sh       <= next_byte;
                        spi_mosi <= next_byte[7];
                        spi_cs_n <= 1'b0;
                        state    <= CS_SETUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    if (READ_EN && is_read) rd_data <= rx;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: target model on the SPI pins plus a byte scoreboard.
// Expectations follow SPI_CMD_MASTER_READ_EN when it is defined for the build.
module tb_spi_cmd_master;

    localparam int SCLK_DIV  = 2;
    localparam int CS_GAP    = 4;
    localparam int READ_WAIT = 16;
    localparam int WR_LAT    = 4 * (17 * SCLK_DIV + CS_GAP) + 1;
    localparam int BUDGET    = 3000;

`ifdef SPI_CMD_MASTER_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    logic        sys_clk  = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        rw_b     = 1'b0;
    logic [16:0] addr     = '0;
    logic [7:0]  wr_data  = '0;
    logic        spi_miso = 1'b0;
    logic        busy, done, spi_sclk, spi_cs_n, spi_mosi;
    logic [7:0]  rd_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    int         gap3_exp  = CS_GAP;
    int         done_cnt  = 0;
    logic [1:0] frame_idx = '0;
    int         edges     = 0;
    int         gap_cnt   = 0;
    logic [7:0] rx_sh     = '0;
    logic [7:0] tx_sh     = '0;
    logic       prev_cs   = 1'b1;
    logic       prev_sclk = 1'b0;

    spi_cmd_master #(.SCLK_DIV(SCLK_DIV), .CS_GAP(CS_GAP), .READ_WAIT(READ_WAIT)) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .start    (start),
        .rw_b     (rw_b),
        .addr     (addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Target model: samples every SPI pin on the falling sys_clk edge, away from DUT updates.
    always @(negedge sys_clk) begin
        if (reset) begin
            exp_q.delete();
            frame_idx = '0;
            edges     = 0;
            gap_cnt   = 0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (prev_cs && !spi_cs_n) begin
                if (frame_idx != 2'd0)
                    check("cs_gap", gap_cnt, (frame_idx == 2'd3) ? gap3_exp : CS_GAP);
                edges    = 0;
                rx_sh    = '0;
                tx_sh    = (frame_idx == 2'd3) ? 8'h3C : 8'hC3;
                spi_miso = tx_sh[7];
            end
            if (!prev_sclk && spi_sclk) begin
                edges++;
                rx_sh = {rx_sh[6:0], spi_mosi};
                check("sclk_rise_cs", spi_cs_n, 0);
            end
            if (prev_sclk && !spi_sclk) begin
                tx_sh    = {tx_sh[6:0], 1'b0};
                spi_miso = tx_sh[7];
            end
            if (!prev_cs && spi_cs_n) begin
                check("frame_edges", edges, 8);
                check("sclk_idle_cs_high", spi_sclk, 0);
                if (exp_q.size() == 0) check("frame_expected", 0, 1);
                else check("frame_byte", rx_sh, exp_q.pop_front());
                frame_idx++;
                gap_cnt = 0;
            end
            if (spi_cs_n) gap_cnt++;
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    task automatic push_frame(input logic rd, input logic [16:0] a, input logic [7:0] d);
        logic r;
        r = RD_EN && rd;
        exp_q.push_back({r, a[16], 6'd0});
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(r ? 8'h00 : d);
        gap3_exp = CS_GAP + (r ? READ_WAIT : 0);
    endtask

    task automatic drive_start(input logic rd, input logic [16:0] a, input logic [7:0] d);
        @(negedge sys_clk);
        start   = 1'b1;
        rw_b    = rd;
        addr    = a;
        wr_data = d;
        @(negedge sys_clk);
        start   = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < BUDGET) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= BUDGET) check("done_timeout", 0, 1);
    endtask

    task automatic run_tx(input string tag, input logic rd, input logic [16:0] a,
                          input logic [7:0] d, input int lat);
        int n;
        push_frame(rd, a, d);
        drive_start(rd, a, d);
        wait_done(0, n);
        check(tag, n, lat);
        check("busy_at_done", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        @(negedge sys_clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dc;

        repeat (3) @(negedge sys_clk);
        check("reset_outputs", {busy, done, rd_data, spi_sclk, spi_cs_n, spi_mosi}, 13'b0_0_00000000_0_1_0);
        reset = 1'b0;
        repeat (100) begin
            @(negedge sys_clk);
            check("idle_pins", {spi_cs_n, spi_sclk, spi_mosi, busy}, 4'b1000);
        end

        run_tx("write_latency", 1'b0, 17'h1_8001, 8'hA5, WR_LAT);
        check("rd_data_after_write", rd_data, 8'h00);

`ifdef SPI_CMD_MASTER_READ_EN
        run_tx("read_latency", 1'b1, 17'h0_E810, 8'h77, WR_LAT + READ_WAIT);
        check("rd_data_read", rd_data, 8'h3C);
`else
        run_tx("rw_ignored_latency", 1'b1, 17'h0_0010, 8'h55, WR_LAT);
        check("rd_data_const", rd_data, 8'h00);
`endif

        // start pulse during B1 must be ignored
        dc = done_cnt;
        push_frame(1'b0, 17'h0_1234, 8'h5A);
        drive_start(1'b0, 17'h0_1234, 8'h5A);
        n = 0;
        repeat (50) begin
            @(negedge sys_clk);
            n++;
        end
        start = 1'b1;
        addr  = 17'h1_FFFF;
        @(negedge sys_clk);
        n++;
        start = 1'b0;
        wait_done(n, n);
        check("ignored_start_latency", n, WR_LAT);
        repeat (200) @(negedge sys_clk);
        check("single_done", done_cnt - dc, 1);
        check("ignored_queue_drained", exp_q.size(), 0);

        // start held high across DONE: second transaction starts the cycle after done
        dc = done_cnt;
        push_frame(1'b0, 17'h0_4321, 8'h96);
        push_frame(1'b0, 17'h0_4321, 8'h96);
        @(negedge sys_clk);
        start   = 1'b1;
        rw_b    = 1'b0;
        addr    = 17'h0_4321;
        wr_data = 8'h96;
        @(negedge sys_clk);
        wait_done(0, n);
        check("b2b_first_latency", n, WR_LAT);
        check("b2b_busy_low_at_done", busy, 0);
        @(negedge sys_clk);
        start = 1'b0;
        check("b2b_restart", {busy, spi_cs_n}, 2'b10);
        wait_done(0, n);
        check("b2b_second_latency", n, WR_LAT);
        repeat (5) @(negedge sys_clk);
        check("b2b_done_count", done_cnt - dc, 2);
        check("b2b_queue_drained", exp_q.size(), 0);

        // reset during B2, then a clean write
        dc = done_cnt;
        push_frame(1'b0, 17'h0_ABCD, 8'h11);
        drive_start(1'b0, 17'h0_ABCD, 8'h11);
        repeat (90) @(negedge sys_clk);
        @(posedge sys_clk);
        #2 reset = 1'b1;
        #1 check("reset_mid_outputs", {busy, done, rd_data, spi_sclk, spi_cs_n, spi_mosi}, 13'b0_0_00000000_0_1_0);
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        repeat (200) @(negedge sys_clk);
        check("no_done_after_reset", done_cnt - dc, 0);
        run_tx("post_reset_latency", 1'b0, 17'h0_0F0F, 8'hC3, WR_LAT);

        repeat (10) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_cmd_master.md
# spi_cmd_master

SPI controller (initiator) for the PET bus-bridge command protocol: turns a single-cycle request (read/write, 17-bit address, data) into a framed SPI transaction toward the FPGA-side target bridge. The target relies on `spi_cs_n` pulsing high between bytes, so every byte is its own chip-select frame. The block sits in the controller-side design (test harness / secondary FPGA) on `sys_clk` and generates SPI mode 0 timing itself.

## Interface
Parameters:
- `SCLK_DIV`, 2: `sys_clk` cycles per SCLK half-period (≥1).
- `CS_GAP`, 4: `sys_clk` cycles `spi_cs_n` is held high between bytes (≥1).
- `READ_WAIT`, 16: extra idle cycles (cs_n high) inserted before the read data byte (≥0).

Ports (one clock; reset is asynchronous and active-high):
- `sys_clk`  input  1  system clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request strobe; sampled only in IDLE.
- `rw_b`  input  1  1 = read, 0 = write; captured with `start`.
- `addr`  input  17  target address; captured with `start`.
- `wr_data`  input  8  write data; captured with `start`.
- `busy`  output  1  high from the edge after `start` accept to the end of the transaction.
- `done`  output  1  one-cycle pulse at transaction end.
- `rd_data`  output  8  last read byte; holds until the next read completes.
- `spi_sclk`  output  1  SPI clock, idle low.
- `spi_cs_n`  output  1  chip select, active low, idle high.
- `spi_mosi`  output  1  controller-to-target data, MSB first.
- `spi_miso`  input  1  target-to-controller data.

## Operation
- Frame is 4 bytes: B0 = `{rw_b, addr[16], 6'd0}` (cmd field 0 = CMD_WRITE opcode), B1 = `addr[15:8]`, B2 = `addr[7:0]`, B3 = `wr_data` for a write, `8'h00` dummy for a read.
- Read: READ_WAIT extra gap cycles before B3; MISO bits shifted during B3 form `rd_data` (MSB first), updated at the `done` edge.
- States: IDLE → CS_SETUP → SCLK_HI ↔ SCLK_LO (8 bits) → GAP → (next byte: CS_SETUP | read before B3: WAIT → CS_SETUP | after B3: DONE) → IDLE.
- IDLE: `start`=1 captures inputs, loads B0 into shifter, `cs_n`←0, `mosi`←bit 7, `busy`←1, → CS_SETUP.
- CS_SETUP: hold SCLK_DIV cycles, then `sclk`←1, → SCLK_HI.
- SCLK_HI: MISO sampled on the edge `sclk` rises; hold SCLK_DIV cycles, then `sclk`←0, shift, `mosi`←next bit, → SCLK_LO.
- SCLK_LO: hold SCLK_DIV cycles; if 8 bits done `cs_n`←1, `mosi`←0, → GAP; else `sclk`←1, → SCLK_HI.
- GAP: hold CS_GAP cycles; byte counter (2-bit) advances, next byte loaded on exit.
- DONE: `done`←1 one cycle, `busy`←0, → IDLE.
- `start` while busy: ignored, no queuing. `start` held high across DONE: new transaction accepted in the following IDLE cycle.
- Half-period counter is `$clog2(max(SCLK_DIV,CS_GAP,READ_WAIT)+1)` wide; no wrap beyond terminal count.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_data`=8'h00, `spi_sclk`=0, `spi_cs_n`=1, `spi_mosi`=0, state IDLE.
- Reset mid-transaction: all outputs return to reset values immediately (async); no `done`; `rd_data` cleared.
- Reset and `start` simultaneous: reset wins.
- Per byte: 17·SCLK_DIV + CS_GAP cycles (setup + 16 half-periods + gap).
- Write latency, accept edge to `done` high: 4·(17·SCLK_DIV+CS_GAP)+1 cycles; read adds READ_WAIT.
- MOSI changes only while `sclk` low or `cs_n` high; ≥SCLK_DIV cycles setup before each rising SCLK.
- Exactly 8 SCLK rising edges per `cs_n` low window; `sclk` low whenever `cs_n` high.

## Configuration
- `SPI_CMD_MASTER_READ_EN` defined: read path as above (READ_WAIT gap, MISO capture, `rd_data` update).
- Undefined: `rw_b` ignored, B0 bit 7 forced 0, every transaction is a write, no WAIT state, `spi_miso` unused, `rd_data` constant 8'h00.

## Test plan
- Reset release, no start: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0 for 100 cycles.
- Write, SCLK_DIV=2, CS_GAP=4, addr=17'h1_8001, wr_data=8'hA5: target model sees bytes 8'h40, 8'h80, 8'h01, 8'hA5, four separate cs_n frames of 8 edges; `done` 153 cycles after accept edge.
- Read (READ_EN), addr=17'h0_E810, target drives 8'h3C on B3: bytes 8'h80, 8'hE8, 8'h10, 8'h00 sent; `rd_data`=8'h3C at `done`; gap before B3 = CS_GAP+READ_WAIT = 20 cycles.
- `start` pulsed during B1 of a write: ignored; exactly one `done`; back-to-back `start` held high yields second transaction beginning one cycle after `done`.
- Reset asserted mid-B2: outputs return to reset values same cycle, no `done`; subsequent write completes correctly.
- READ_EN undefined, `rw_b`=1, addr=17'h0_0010, wr_data=8'h55: B0=8'h00, B3=8'h55, `rd_data` stays 8'h00.
